// File: rtl/lz_feed_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : lz_feed_ctrl
// Brief    : Sequencer for the LZ compressor datapath. Latches one message
//            block, streams its first msg_len bytes to the compressor core
//            over a valid/ready byte channel, then collects output tokens
//            until end-of-message, a protocol error or a drain timeout.
// Revision : 1.0  initial release
// ============================================================================
module lz_feed_ctrl #(
  parameter int MSG_BYTES     = 64,
  parameter int DRAIN_TIMEOUT = 255
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic                   start,
  input  logic [MSG_BYTES*8-1:0] msg_in,
  input  logic [6:0]             msg_len,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic [7:0]             byte_data,
  output logic                   byte_valid,
  output logic                   byte_last,
  input  logic                   byte_ready,
  input  logic                   tok_valid,
  input  logic                   tok_last,
  output logic                   tok_ready,
  output logic [6:0]             tok_count
);

  localparam int MSG_W  = MSG_BYTES * 8;
  // Idle counter must be able to hold DRAIN_TIMEOUT itself.
  localparam int IDLE_W = (DRAIN_TIMEOUT < 1) ? 1 : $clog2(DRAIN_TIMEOUT + 1);
  localparam logic [IDLE_W-1:0] TIMEOUT_VAL = IDLE_W'(DRAIN_TIMEOUT);
  localparam logic [6:0]        MAX_LEN     = 7'(MSG_BYTES);
  localparam logic [6:0]        TOK_MAX     = 7'd127;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SEND  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]        state;
  logic [1:0]        state_next;
  logic [MSG_W-1:0]  shreg;
  logic [6:0]        len_m1;
  logic [6:0]        byte_cnt;
  logic [IDLE_W-1:0] idle_cnt;
  // A tok_last that arrived together with the final byte: finish cleanly
  // from DRAIN on the next edge instead of flagging a protocol error.
  logic              last_seen;

  logic len_ok;
  logic start_acc;
  logic byte_fire;
  logic last_fire;
  logic tok_fire;
  logic tok_end;
  logic early_last;
  logic timeout_hit;

  // Handshake and event decode; all terms come from registers or inputs
  // feeding registers, never directly to an output.
  assign len_ok      = (msg_len != 7'd0) && (msg_len <= MAX_LEN);
  assign start_acc   = (state == S_IDLE) && start;
  assign byte_fire   = byte_valid && byte_ready;
  assign last_fire   = byte_fire && byte_last;
  assign tok_fire    = tok_valid && tok_ready;
  assign tok_end     = tok_fire && tok_last;
  assign early_last  = (state == S_SEND) && tok_end && !last_fire;
  assign timeout_hit = (state == S_DRAIN) && !last_seen && !tok_fire &&
                       (idle_cnt == TIMEOUT_VAL);

  // State register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_next = len_ok ? S_SEND : S_DONE;
        end
      end
      S_SEND: begin
        // Final byte wins over a same-edge tok_last: that case is legal.
        if (last_fire) begin
          state_next = S_DRAIN;
        end else if (tok_end) begin
          state_next = S_DONE;
        end
      end
      S_DRAIN: begin
        if (last_seen || tok_end || timeout_hit) begin
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Moore outputs decoded from the state and datapath registers.
  always_comb begin
    busy       = (state != S_IDLE);
    done       = (state == S_DONE);
    byte_valid = (state == S_SEND);
    byte_last  = (state == S_SEND) && (byte_cnt == len_m1);
    tok_ready  = (state == S_SEND) || (state == S_DRAIN);
    byte_data  = shreg[MSG_W-1 -: 8];
  end

  // Message shift register, byte counter and latched length.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      shreg    <= '0;
      byte_cnt <= 7'd0;
      len_m1   <= 7'd0;
    end else if (start_acc) begin
      byte_cnt <= 7'd0;
      if (len_ok) begin
        shreg  <= msg_in;
        len_m1 <= msg_len - 7'd1;
      end
    end else if (byte_fire) begin
      shreg    <= {shreg[MSG_W-9:0], 8'h00};
      byte_cnt <= byte_cnt + 7'd1;
    end
  end

  // Token counter, saturating so a chatty core cannot wrap it.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      tok_count <= 7'd0;
    end else if (start_acc) begin
      tok_count <= 7'd0;
    end else if (tok_fire && (tok_count != TOK_MAX)) begin
      tok_count <= tok_count + 7'd1;
    end
  end

  // Drain idle counter: cleared outside DRAIN and on every accepted token.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      idle_cnt <= '0;
    end else if (state != S_DRAIN) begin
      idle_cnt <= '0;
    end else if (tok_fire) begin
      idle_cnt <= '0;
    end else if (idle_cnt != TIMEOUT_VAL) begin
      idle_cnt <= idle_cnt + IDLE_W'(1);
    end
  end

  // Error flag and end-of-message-with-final-byte marker, both per job.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      err       <= 1'b0;
      last_seen <= 1'b0;
    end else if (start_acc) begin
      err       <= !len_ok;
      last_seen <= 1'b0;
    end else begin
      if (early_last || timeout_hit) begin
        err <= 1'b1;
      end
      if (last_fire && tok_end) begin
        last_seen <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lz_feed_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_lz_feed_ctrl
// Brief    : Scoreboard bench for lz_feed_ctrl. The driver pushes expected
//            bytes and end-of-job records; a negedge monitor pops and
//            compares whenever the DUT presents a byte or a done pulse.
// Revision : 1.0  initial release
// ============================================================================
module tb_lz_feed_ctrl;

  localparam int MSG_BYTES     = 64;
  localparam int DRAIN_TIMEOUT = 8;
  localparam int MSG_W         = MSG_BYTES * 8;

  logic             CLK        = 1'b0;
  logic             RST_N      = 1'b0;
  logic             start      = 1'b0;
  logic [MSG_W-1:0] msg_in     = '0;
  logic [6:0]       msg_len    = 7'd0;
  logic             byte_ready = 1'b0;
  logic             tok_valid  = 1'b0;
  logic             tok_last   = 1'b0;
  logic             busy;
  logic             done;
  logic             err;
  logic [7:0]       byte_data;
  logic             byte_valid;
  logic             byte_last;
  logic             tok_ready;
  logic [6:0]       tok_count;

  lz_feed_ctrl #(
    .MSG_BYTES     (MSG_BYTES),
    .DRAIN_TIMEOUT (DRAIN_TIMEOUT)
  ) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .start      (start),
    .msg_in     (msg_in),
    .msg_len    (msg_len),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .byte_data  (byte_data),
    .byte_valid (byte_valid),
    .byte_last  (byte_last),
    .byte_ready (byte_ready),
    .tok_valid  (tok_valid),
    .tok_last   (tok_last),
    .tok_ready  (tok_ready),
    .tok_count  (tok_count)
  );

  always #5 CLK = ~CLK;

  // Edge counter: between edges it holds the number of the last rising edge.
  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] data;
    logic       last;
  } byte_exp_t;

  typedef struct {
    logic       err;
    logic [6:0] tok;
    int         xfers;
    int         done_cyc;
    int         span;
  } done_exp_t;

  byte_exp_t byte_q[$];
  done_exp_t done_q[$];

  int checks = 0;
  int errors = 0;

  logic [167:0] hdr = "Hello my name is Leah";
  logic [7:0]   mb [MSG_BYTES];
  logic [MSG_W-1:0] msg_vec;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push_b(input logic [7:0] d, input logic l);
    byte_exp_t e;
    e.data = d;
    e.last = l;
    byte_q.push_back(e);
  endtask

  task automatic push_d(input logic e, input logic [6:0] t, input int x, input int dc, input int sp);
    done_exp_t r;
    r.err      = e;
    r.tok      = t;
    r.xfers    = x;
    r.done_cyc = dc;
    r.span     = sp;
    done_q.push_back(r);
  endtask

  task automatic start_job(input logic [6:0] len);
    msg_in  = msg_vec;
    msg_len = len;
    start   = 1'b1;
    tick();
    start   = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 300) begin
      tick();
      n++;
    end
    if (busy) chk("wait_idle_timeout", 64'(busy), 64'd0);
  endtask

  // Monitor: compare presented bytes against the queue head every cycle
  // (so stalls must hold the data), pop on transfer, check each done pulse.
  int        mon_xfers = 0;
  int        mon_first = 0;
  int        mon_last  = 0;
  byte_exp_t mon_b;
  done_exp_t mon_d;

  always @(negedge CLK) begin
    if (!RST_N) begin
      mon_xfers = 0;
      mon_first = 0;
      mon_last  = 0;
    end else begin
      if (byte_valid) begin
        if (byte_q.size() > 0) begin
          chk("byte_data", 64'(byte_data), 64'(byte_q[0].data));
          chk("byte_last", 64'(byte_last), 64'(byte_q[0].last));
          if (byte_ready) mon_b = byte_q.pop_front();
        end else if (byte_ready) begin
          chk("unexpected_byte", 64'(byte_valid & byte_ready), 64'd0);
        end
        if (byte_ready) begin
          if (mon_xfers == 0) mon_first = cyc + 1;
          mon_last = cyc + 1;
          mon_xfers++;
        end
      end
      if (done) begin
        if (done_q.size() == 0) begin
          chk("unexpected_done", 64'(done), 64'd0);
        end else begin
          mon_d = done_q.pop_front();
          chk("done_err", 64'(err), 64'(mon_d.err));
          chk("done_tok_count", 64'(tok_count), 64'(mon_d.tok));
          chk("done_xfers", 64'(mon_xfers), 64'(mon_d.xfers));
          chk("done_busy", 64'(busy), 64'd1);
          chk("done_leftover_bytes", 64'(byte_q.size()), 64'd0);
          if (mon_d.done_cyc >= 0) chk("done_cycle", 64'(cyc), 64'(mon_d.done_cyc));
          if (mon_d.span >= 0) chk("xfer_span", 64'(mon_last - mon_first + 1), 64'(mon_d.span));
        end
        mon_xfers = 0;
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    for (int i = 0; i < MSG_BYTES; i++) begin
      if (i < 21)       mb[i] = hdr[8*(20-i) +: 8];
      else if (i == 63) mb[i] = 8'h29;
      else              mb[i] = 8'h61 + 8'(i % 26);
      msg_vec[MSG_W-1-8*i -: 8] = mb[i];
    end

    // Reset values
    tick();
    tick();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_byte_valid", 64'(byte_valid), 64'd0);
    chk("rst_tok_ready", 64'(tok_ready), 64'd0);
    chk("rst_tok_count", 64'(tok_count), 64'd0);
    RST_N = 1'b1;
    tick();

    // Basic: 5 bytes "Hello", 5 tokens returned in DRAIN
    n = cyc + 1;
    push_b(8'h48, 1'b0);
    push_b(8'h65, 1'b0);
    push_b(8'h6C, 1'b0);
    push_b(8'h6C, 1'b0);
    push_b(8'h6F, 1'b1);
    push_d(1'b0, 7'd5, 5, n + 10, 5);
    byte_ready = 1'b1;
    start_job(7'd5);
    chk("busy_after_start", 64'(busy), 64'd1);
    chk("first_byte_valid", 64'(byte_valid), 64'd1);
    repeat (5) tick();
    for (int k = 0; k < 5; k++) begin
      tok_valid = 1'b1;
      tok_last  = (k == 4);
      tick();
    end
    tok_valid = 1'b0;
    tok_last  = 1'b0;
    wait_idle();
    chk("basic_err_held", 64'(err), 64'd0);

    // Backpressure: 64 bytes, ready toggling, 3 tokens in SEND + final in DRAIN
    n = cyc + 1;
    for (int i = 0; i < MSG_BYTES; i++) push_b(mb[i], (i == 63));
    push_d(1'b0, 7'd4, 64, n + 128, 127);
    byte_ready = 1'b1;
    tok_valid  = 1'b1;
    tok_last   = 1'b0;
    start_job(7'd64);
    for (int j = 1; j <= 127; j++) begin
      tick();
      byte_ready = (j % 2 == 0);
      if (j == 3) tok_valid = 1'b0;
      if (j == 127) begin
        tok_valid = 1'b1;
        tok_last  = 1'b1;
      end
    end
    tick();
    tok_valid  = 1'b0;
    tok_last   = 1'b0;
    byte_ready = 1'b1;
    wait_idle();

    // Invalid lengths 0 and 65: immediate done with err, nothing sent
    for (int t = 0; t < 2; t++) begin
      n = cyc + 1;
      push_d(1'b1, 7'd0, 0, n, -1);
      start_job((t == 0) ? 7'd0 : 7'd65);
      wait_idle();
      chk("invalid_err_held", 64'(err), 64'd1);
      chk("invalid_byte_valid", 64'(byte_valid), 64'd0);
    end

    // Early tok_last after 3 of 10 bytes
    n = cyc + 1;
    push_b(8'h48, 1'b0);
    push_b(8'h65, 1'b0);
    push_b(8'h6C, 1'b0);
    push_d(1'b1, 7'd1, 3, n + 4, 3);
    byte_ready = 1'b1;
    start_job(7'd10);
    repeat (3) tick();
    byte_ready = 1'b0;
    tok_valid  = 1'b1;
    tok_last   = 1'b1;
    tick();
    tok_valid  = 1'b0;
    tok_last   = 1'b0;
    byte_ready = 1'b1;
    wait_idle();
    chk("early_err_held", 64'(err), 64'd1);

    // Timeout with no tokens: done 9 edges after DRAIN entry (edge n+3)
    n = cyc + 1;
    push_b(8'h48, 1'b0);
    push_b(8'h65, 1'b0);
    push_b(8'h6C, 1'b1);
    push_d(1'b1, 7'd0, 3, n + 12, 3);
    start_job(7'd3);
    wait_idle();

    // Timeout restarted by a token accepted in DRAIN at edge n+5
    n = cyc + 1;
    push_b(8'h48, 1'b0);
    push_b(8'h65, 1'b1);
    push_d(1'b1, 7'd1, 2, n + 14, 2);
    start_job(7'd2);
    repeat (4) tick();
    tok_valid = 1'b1;
    tok_last  = 1'b0;
    tick();
    tok_valid = 1'b0;
    wait_idle();

    // tok_last on the same edge as the final byte: legal, done one edge later
    n = cyc + 1;
    push_b(8'h48, 1'b0);
    push_b(8'h65, 1'b0);
    push_b(8'h6C, 1'b0);
    push_b(8'h6C, 1'b1);
    push_d(1'b0, 7'd1, 4, n + 5, 4);
    start_job(7'd4);
    repeat (3) tick();
    tok_valid = 1'b1;
    tok_last  = 1'b1;
    tick();
    tok_valid = 1'b0;
    tok_last  = 1'b0;
    wait_idle();
    chk("same_edge_err_held", 64'(err), 64'd0);

    // Asynchronous reset in the middle of SEND, after two bytes
    push_b(8'h48, 1'b0);
    push_b(8'h65, 1'b0);
    push_b(8'h6C, 1'b0);
    tok_valid = 1'b1;
    tok_last  = 1'b0;
    start_job(7'd10);
    tick();
    tok_valid = 1'b0;
    tick();
    chk("pre_reset_tok_count", 64'(tok_count), 64'd1);
    chk("pre_reset_byte_data", 64'(byte_data), 64'h6C);
    #2;
    RST_N = 1'b0;
    #1;
    chk("async_rst_busy", 64'(busy), 64'd0);
    chk("async_rst_done", 64'(done), 64'd0);
    chk("async_rst_err", 64'(err), 64'd0);
    chk("async_rst_byte_valid", 64'(byte_valid), 64'd0);
    chk("async_rst_byte_last", 64'(byte_last), 64'd0);
    chk("async_rst_byte_data", 64'(byte_data), 64'd0);
    chk("async_rst_tok_ready", 64'(tok_ready), 64'd0);
    chk("async_rst_tok_count", 64'(tok_count), 64'd0);
    byte_q.delete();
    tick();
    tick();
    RST_N = 1'b1;
    tick();

    // Fresh 2-byte job after reset starts again from byte 0x48
    n = cyc + 1;
    push_b(8'h48, 1'b0);
    push_b(8'h65, 1'b1);
    push_d(1'b0, 7'd1, 2, n + 3, 2);
    start_job(7'd2);
    repeat (2) tick();
    tok_valid = 1'b1;
    tok_last  = 1'b1;
    tick();
    tok_valid = 1'b0;
    tok_last  = 1'b0;
    wait_idle();

    repeat (3) tick();
    chk("byte_q_drained", 64'(byte_q.size()), 64'd0);
    chk("done_q_drained", 64'(done_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/lz_feed_ctrl.md
# lz_feed_ctrl

Sequencer for the LZ compressor datapath. Accepts one 512-bit message block (64 ASCII bytes, byte 0 in bits [511:504], the same packing the binary-to-string stage consumes), streams its first msg_len bytes to the compressor core over a valid/ready byte channel, then collects the core's output tokens until end-of-message. Reports completion, the token count and protocol or timeout errors to the top-level control.

## Interface

Parameters:
- MSG_BYTES, 64, bytes per message block; message width is MSG_BYTES*8.
- DRAIN_TIMEOUT, 255, maximum cycles in DRAIN without an accepted token before error.

Ports:
- CLK  in  1  single clock; all logic on the rising edge.
- RST_N  in  1  reset, asynchronous and active-low.
- start  in  1  one-cycle request; sampled only in IDLE.
- msg_in  in  512  message block, latched on an accepted start.
- msg_len  in  7  bytes to send, 1..64; latched on an accepted start.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at end of job.
- err  out  1  error flag for the last job; valid with done and held until the next accepted start.
- byte_data  out  8  current byte to the core.
- byte_valid  out  1  byte_data is valid.
- byte_last  out  1  current byte is the final byte of the message.
- byte_ready  in  1  core accepts the byte.
- tok_valid  in  1  core presents a token.
- tok_last  in  1  current token is the final token.
- tok_ready  out  1  controller accepts the token.
- tok_count  out  7  tokens accepted in the current or last job; saturates at 127.

## Operation

States: IDLE, SEND, DRAIN, DONE.

- IDLE
  - start with msg_len in 1..64: latch msg_in into a shift register and msg_len into a register. Clear the byte counter, tok_count and err. Go to SEND.
  - start with msg_len = 0 or > 64: set err=1 and go to DONE. Nothing is sent.
  - start while busy is ignored.
- SEND
  - byte_valid=1; byte_data = shreg[511:504].
  - byte_last=1 when byte counter == len-1.
  - On byte_valid & byte_ready: shift left by 8 and increment the counter.
  - If that transfer was byte_last, go to DRAIN.
  - byte_data, byte_valid and byte_last stay stable while byte_ready is low.
- Token channel
  - tok_ready=1 in SEND and DRAIN, 0 otherwise.
  - Each tok_valid & tok_ready increments tok_count, saturating at 127.
- tok_last accepted in SEND (before the final byte is transferred): protocol error. Set err=1 and go to DONE. Remaining bytes are discarded.
- DRAIN
  - On tok_valid & tok_ready & tok_last, go to DONE.
  - The idle counter resets on every accepted token. When it reaches DRAIN_TIMEOUT, set err=1 and go to DONE.
- DONE: done=1 for exactly one cycle, then go to IDLE.
- Reset (asynchronous, any state, including mid-message), all to 0:
  - state IDLE
  - busy, done, err, byte_valid, byte_last, byte_data, tok_ready, tok_count
  - shift register and all counters
- Error exits also leave tok_count holding the tokens accepted so far.

## Timing

- start is accepted at edge N. From N+1: busy=1, byte_valid=1 with byte 0.
- Throughput is one byte per cycle while byte_ready is held high. For msg_len=L with ready always high, the last byte transfers at edge N+L and DRAIN is entered after that edge.
- tok_last accepted at edge M: DONE at M+1, done=1 during cycle M+1, busy=0 from M+2.
- A tok_last accepted on the same edge as the final byte transfer is legal: the job completes via DRAIN, done at M+2, and there is no error.
- The invalid-length path produces done at N+1 with err=1.
- Timeout: done is asserted DRAIN_TIMEOUT+1 cycles after the last accepted token, or after DRAIN entry if no token was accepted.
- No combinational path from any input to any output; all outputs are registered.

## Test plan

- Basic message: message block starting "Hello my name is Leah…" (0x48,0x65,0x6C,…), msg_len=5, ready high, core returns 5 tokens with tok_last on the 5th.
  - Required: byte_data sequence 0x48,0x65,0x6C,0x6C,0x6F; byte_last only on 0x6F; tok_count=5; done pulse; err=0.
- Backpressure: msg_len=64, byte_ready toggling 1/0 each cycle.
  - Required: 64 transfers in 127 cycles; byte_data stable during stalls; last byte 0x29.
- Invalid length: msg_len=0.
  - Required: done at N+1, err=1, byte_valid never high.
  - Repeat with msg_len=65: same result.
- Early tok_last: tok_last asserted after 3 of 10 bytes.
  - Required: err=1, done, only 3 byte transfers, tok_count=1.
- Timeout: DRAIN_TIMEOUT=8, no tokens returned.
  - Required: done with err=1 exactly 9 cycles after DRAIN entry.
- Reset mid-SEND: RST_N low after byte 2.
  - Required: all outputs 0 immediately, asynchronously.
  - Then a fresh start with msg_len=2 completes normally starting from byte 0x48.
